line_window_3x3: RTL
====================

// Module: line_window_3x3
// PURPOSE
//  Downstream neighbour of the row-padding stage. Turns the padded raster pixel stream into
//  3x3 neighbourhood windows for the Gaussian and Sobel kernels of the Canny pipeline.
//  Two WIDTH-deep line buffers plus a 3x3 register array produce one window per accepted pixel.
//  Output covers only fully-populated interior windows; vertical zero rows come from upstream.
// PARAMETERS
//  DATA_WIDTH  16   pixel width in bits
//  WIDTH       640  active pixels per line (blanking excluded)
//  ROWS        512  lines per frame including upstream padding rows (504 + 2*4)
//  CW          11   width of column/row counters and coordinate outputs (>= clog2 of WIDTH and ROWS)
// PORTS
//  clk         in   1             clock, rising edge
//  rst_n       in   1             asynchronous, active-low reset
//  frame_en    in   1             high for the whole frame; low clears counters and aborts the frame
//  pix_valid   in   1             pix_in is accepted this cycle (upstream data-enable)
//  pix_in      in   DATA_WIDTH    padded pixel, raster order
//  win_valid   out  1             win_out, out_row and out_col are valid this cycle
//  win_out     out  9*DATA_WIDTH  window; slice [DATA_WIDTH*(3*r+c) +: DATA_WIDTH] = pixel(cr-1+r, cc-1+c)
//  out_row     out  CW            window centre row cr
//  out_col     out  CW            window centre column cc
//  frame_done  out  1             one-cycle pulse marking the last window of the frame
// BEHAVIOUR
//  Reset (async, immediate)
//  - win_valid=0, win_out=0, out_row=0, out_col=0, frame_done=0.
//  - Internal col/row counters are 0. Line-buffer RAM contents are not cleared.
//  Accept and counters
//  - A pixel is accepted when frame_en && pix_valid.
//  - col counts 0..WIDTH-1 and wraps to 0. On that wrap, row increments 0..ROWS-1.
//  - After pixel (ROWS-1, WIDTH-1), both counters return to 0. A new frame may follow directly while frame_en stays high.
//  - Cycles with pix_valid=0 (blanking, holes) hold all state and drive win_valid=0.
//  Line buffers (accept at column c)
//  - top = lb2[c], mid = lb1[c], bot = pix_in.
//  - Same edge: lb1[c] <= pix_in and lb2[c] <= old lb1[c].
//  - Read-during-write returns old data (read-first). Any RAM style is allowed if the cycle timing below is preserved.
//  Window array
//  - Per row r in {top, mid, bot}: w[r][0] <= w[r][1], w[r][1] <= w[r][2], w[r][2] <= new tap.
//  Latency and output
//  - win_valid is registered: high exactly 1 cycle after accepting pixel (row, col) with row >= 2 and col >= 2.
//  - In that cycle: out_row = row-1, out_col = col-1, win_out = registered window, r=0 oldest line, c=0 leftmost.
//  - Each frame yields (WIDTH-2)*(ROWS-2) windows.
//  - The window array is not cleared at line start: columns 0 and 1 only refill it, so no cross-line data leaks out.
//  - win_out holds its last value while win_valid=0.
//  frame_done
//  - Pulses coincident with the win_valid of the window centred at (ROWS-2, WIDTH-2).
//  frame_en low
//  - Next edge: counters -> 0, win_valid=0, frame_done=0; pix_valid is ignored.
//  - A mid-frame drop discards the partial frame. The next frame_en high starts a clean frame at row 0.
//  - Stale line-buffer data is harmless because rows 0 and 1 are never emitted.
//  Simultaneous events
//  - frame_en falling on the same cycle as an accept: the accept is ignored (frame_en gates it).
//  - Last pixel of a frame accepted: counter wrap and frame_done occur with no bubble.
//  Arithmetic
//  - Counters are unsigned CW bits. Coordinates are combinational from the counters and registered at output; no saturation required.
// TESTING
//  1 WIDTH=8, ROWS=6, pix=row*16+col, pix_valid continuous
//    -> first win_valid 1 cycle after pixel (2,2) with win_out = {22,21,20,12,11,10,02,01,00}h, centre 0x11.
//    -> 24 windows total; frame_done on the window with centre (4,6).
//  2 Same frame with 3 blanking cycles per line plus random pix_valid holes
//    -> window sequence and coordinates identical to test 1; win_valid never high during holes.
//  3 Two back-to-back frames with frame_en held high, frame 2 = pix+0x80
//    -> frame_done pulses exactly twice; first window of frame 2 = centre 0x91, no frame-1 values present.
//  4 Drop frame_en for 1 cycle at pixel (3,4), then replay the full frame
//    -> win_valid=0 the next cycle, out_row/out_col=0; replayed frame matches test 1 exactly.
//  5 Assert rst_n=0 asynchronously mid-line (not clock-aligned)
//    -> all outputs 0 before the next clk edge; after release a full frame matches test 1.
//  6 Upstream-style padded frame: rows 0,1 and 4,5 zero, others ramp
//    -> windows centred on row 1 have zero top/mid rows; row-4 centres have a zero bottom row.

Source files
------------

// File: rtl/line_window_3x3.sv
// Purpose: turns a padded raster pixel stream into 3x3 windows via two line buffers and a 3x3 register array.
// Latency: one cycle from accepting pixel (row, col) to the window centred at (row-1, col-1).
// Backpressure: none; pix_valid is a data-enable, holes and blanking simply hold all state.
module line_window_3x3 #(
    parameter int DATA_WIDTH = 16,
    parameter int WIDTH      = 640,
    parameter int ROWS       = 512,
    parameter int CW         = 11
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      frame_en,
    input  logic                      pix_valid,
    input  logic [DATA_WIDTH-1:0]     pix_in,
    output logic                      win_valid,
    output logic [9*DATA_WIDTH-1:0]   win_out,
    output logic [CW-1:0]             out_row,
    output logic [CW-1:0]             out_col,
    output logic                      frame_done
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [CW-1:0] col, row;
    logic [AW-1:0] col_a;
    logic          accept, last_col, last_row, emit;

    logic [DW-1:0] lb1 [WIDTH];
    logic [DW-1:0] lb2 [WIDTH];
    logic [DW-1:0] tap [3];
    logic [DW-1:0] w   [3][3];
    logic [DW-1:0] nw  [3][3];
    logic [9*DW-1:0] win_next;

    assign col_a    = col[AW-1:0];
    assign accept   = frame_en && pix_valid;
    assign last_col = (col == CW'(WIDTH - 1));
    assign last_row = (row == CW'(ROWS - 1));
    // Rows 0/1 and columns 0/1 only prime the buffers and window array.
    assign emit     = accept && (row >= CW'(2)) && (col >= CW'(2));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (!frame_en) begin
            col <= '0;
            row <= '0;
        end else if (accept) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + CW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Read-first line buffers: taps see the values stored before this edge.
    assign tap[0] = lb2[col_a];
    assign tap[1] = lb1[col_a];
    assign tap[2] = pix_in;

    always_ff @(posedge clk) begin
        if (accept) begin
            lb1[col_a] <= pix_in;
            lb2[col_a] <= lb1[col_a];
        end
    end

    always_comb begin
        for (int r = 0; r < 3; r++) begin
            nw[r][0] = w[r][1];
            nw[r][1] = w[r][2];
            nw[r][2] = tap[r];
        end
    end

    always_comb begin
        win_next = '0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                win_next[DW*(3*r+c) +: DW] = nw[r][c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    w[r][c] <= nw[r][c];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid  <= 1'b0;
            win_out    <= '0;
            out_row    <= '0;
            out_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= emit;
            frame_done <= emit && last_row && last_col;
            if (emit) begin
                win_out <= win_next;
                out_row <= row - CW'(1);
                out_col <= col - CW'(1);
            end else if (!frame_en) begin
                out_row <= '0;
                out_col <= '0;
            end
        end
    end

endmodule
